// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regbank_pkg
// Purpose  : Shared constants, types and helpers for the 8x64 register bank.
//            Holds the bank geometry, the write-enable classification type and
//            the decoder-order address-to-index mapping.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package regbank_pkg;

    localparam int NUM_REGS     = 8;
    localparam int REG_WIDTH    = 64;
    localparam int ZERO_REG_IDX = 7;
    localparam int ADDR_W       = 3;

    // Classification of the incoming write-enable vector.
    typedef enum logic [1:0] {
        WE_NONE   = 2'd0,
        WE_SINGLE = 2'd1,
        WE_MULTI  = 2'd2
    } we_kind_t;

    // The upstream 3-to-8 decoder treats address bit 0 as the MSB of the
    // register index, so the index is the bit-reversed address.
    function automatic logic [ADDR_W-1:0] addr_to_idx(input logic [ADDR_W-1:0] addr);
        return {addr[0], addr[1], addr[2]};
    endfunction

endpackage : regbank_pkg
`default_nettype wire

// File: rtl/register_bank_8x64_register_en.sv
`default_nettype none
// ============================================================================
// Module   : register_en
// Purpose  : WIDTH-bit storage register with load enable and asynchronous
//            active-high reset.
// Ports    : clk   - clock, rising edge
//            reset - asynchronous active-high clear
//            en    - load enable
//            d     - data in
//            q     - registered data out
// Revision : 1.0  initial release
// ============================================================================
module register_en #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : register_en
`default_nettype wire

// File: rtl/register_bank_8x64.sv
`default_nettype none
// ============================================================================
// Module   : register_bank_8x64
// Purpose  : Eight-entry register bank fed by a one-hot write-enable vector,
//            with two combinational read ports, an optional hardwired zero
//            register (index 7), optional write-to-read bypass and a sticky
//            flag for illegal multi-hot write enables.
// Ports    : clk           - clock, rising edge
//            reset         - asynchronous active-high clear of all state
//            wr_en[7:0]    - one-hot write enable, bit i selects register i
//            wr_data       - write data
//            rd_addr_a/b   - read addresses (decoder bit order)
//            err_clr       - synchronous clear of err_multi_hot
//            rd_data_a/b   - read data
//            err_multi_hot - sticky multi-hot write-enable indicator
// Revision : 1.0  initial release
// ============================================================================
module register_bank_8x64
    import regbank_pkg::*;
#(
    parameter int WIDTH       = REG_WIDTH,
    parameter int ZERO_REG_EN = 1,
    parameter int BYPASS_EN   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REGS-1:0] wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    input  logic                err_clr,
    output logic [WIDTH-1:0]    rd_data_a,
    output logic [WIDTH-1:0]    rd_data_b,
    output logic                err_multi_hot
);

    localparam logic [ADDR_W-1:0] c_zero_idx = ADDR_W'(ZERO_REG_IDX);
    localparam logic              c_zero_en  = (ZERO_REG_EN != 0);

    // ------------------------------------------------------------------
    // Write-enable classification: none / exactly one / two or more.
    // Clearing the lowest set bit leaves zero only for a single-hot vector.
    // ------------------------------------------------------------------
    logic     w_any;
    logic     w_at_most_one;
    we_kind_t w_we_kind;
    logic     w_single;
    logic     w_multi;

    assign w_any         = |wr_en;
    assign w_at_most_one = ((wr_en & (wr_en - NUM_REGS'(1))) == '0);

    always_comb begin
        w_we_kind = WE_NONE;
        if (w_any) begin
            w_we_kind = w_at_most_one ? WE_SINGLE : WE_MULTI;
        end
    end

    assign w_single = (w_we_kind == WE_SINGLE);
    assign w_multi  = (w_we_kind == WE_MULTI);

    // ------------------------------------------------------------------
    // Storage: eight enabled registers; the zero register is a constant.
    // A multi-hot vector enables nothing, so the whole write is dropped.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_regs [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            if (c_zero_en && (gi == ZERO_REG_IDX)) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_store
                register_en #(
                    .WIDTH (WIDTH)
                ) u_reg (
                    .clk   (clk),
                    .reset (reset),
                    .en    (w_single & wr_en[gi]),
                    .d     (wr_data),
                    .q     (w_regs[gi])
                );
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sticky error flag: multi-hot set beats clear beats hold.
    // ------------------------------------------------------------------
    logic r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_multi) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign err_multi_hot = r_err;

    // ------------------------------------------------------------------
    // Read multiplexers (addresses mapped through the decoder bit order).
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_idx_a;
    logic [ADDR_W-1:0] w_idx_b;
    logic [WIDTH-1:0]  w_mux_a;
    logic [WIDTH-1:0]  w_mux_b;

    assign w_idx_a = addr_to_idx(rd_addr_a);
    assign w_idx_b = addr_to_idx(rd_addr_b);
    assign w_mux_a = w_regs[w_idx_a];
    assign w_mux_b = w_regs[w_idx_b];

    // ------------------------------------------------------------------
    // Optional bypass: forward wr_data only when the write will really
    // land, i.e. single-hot, not into the zero register, not in reset.
    // ------------------------------------------------------------------
    generate
        if (BYPASS_EN != 0) begin : g_bypass
            logic [ADDR_W-1:0] w_wr_idx;
            logic              w_fwd_ok;
            logic              w_hit_a;
            logic              w_hit_b;

            always_comb begin
                w_wr_idx = '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_en[i]) begin
                        w_wr_idx = w_wr_idx | ADDR_W'(i);
                    end
                end
            end

            assign w_fwd_ok = w_single && !reset &&
                              !(c_zero_en && (w_wr_idx == c_zero_idx));
            assign w_hit_a  = w_fwd_ok && (w_wr_idx == w_idx_a);
            assign w_hit_b  = w_fwd_ok && (w_wr_idx == w_idx_b);

            assign rd_data_a = w_hit_a ? wr_data : w_mux_a;
            assign rd_data_b = w_hit_b ? wr_data : w_mux_b;
        end else begin : g_no_bypass
            assign rd_data_a = w_mux_a;
            assign rd_data_b = w_mux_b;
        end
    endgenerate

endmodule : register_bank_8x64
`default_nettype wire

// File: tb/tb_register_bank_8x64.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_bank_8x64
// Purpose  : Self-checking bench for register_bank_8x64. Two instances share
//            stimulus: u_dut0 (zero register on, no bypass) and u_dut1 (zero
//            register off, bypass on). A behavioural array model predicts
//            every read and the error flag.
// Revision : 1.0  initial release
// ============================================================================
module tb_register_bank_8x64;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  wr_en;
    logic [63:0] wr_data;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic        err_clr;
    logic [63:0] rd_data_a0, rd_data_b0, rd_data_a1, rd_data_b1;
    logic        err0, err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_bank_8x64 #(.WIDTH(64), .ZERO_REG_EN(1), .BYPASS_EN(0)) u_dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .err_clr(err_clr),
        .rd_data_a(rd_data_a0), .rd_data_b(rd_data_b0), .err_multi_hot(err0));

    register_bank_8x64 #(.WIDTH(64), .ZERO_REG_EN(0), .BYPASS_EN(1)) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .err_clr(err_clr),
        .rd_data_a(rd_data_a1), .rd_data_b(rd_data_b1), .err_multi_hot(err1));

    // ------------------------------------------------------------------
    // Reference model: m[inst][register], exp_err shared by both instances.
    // ------------------------------------------------------------------
    logic [63:0] m [2][8];
    logic        exp_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++)
                for (int j = 0; j < 8; j++)
                    m[k][j] <= 64'd0;
            exp_err <= 1'b0;
        end else begin
            if ($countones(wr_en) == 1) begin
                for (int j = 0; j < 8; j++) begin
                    if (wr_en[j]) begin
                        if (j != 7) m[0][j] <= wr_data;
                        m[1][j] <= wr_data;
                    end
                end
            end
            if ($countones(wr_en) >= 2) exp_err <= 1'b1;
            else if (err_clr)           exp_err <= 1'b0;
        end
    end

    function automatic int reg_index(input logic [2:0] addr);
        return addr[0] * 4 + addr[1] * 2 + addr[2];
    endfunction

    // Expected read value for instance inst at address addr, current inputs.
    function automatic logic [63:0] model_rd(input int inst, input logic [2:0] addr);
        int idx;
        idx = reg_index(addr);
        if (inst == 0 && idx == 7) return 64'd0;
        if (inst == 1 && !reset && $countones(wr_en) == 1 && wr_en[idx]) return wr_data;
        return m[inst][idx];
    endfunction

    task automatic drive_write(input int idx, input logic [63:0] d);
        @(negedge clk);
        wr_en   = 8'd1 << idx;
        wr_data = d;
        err_clr = 1'b0;
        @(negedge clk);
        wr_en   = 8'd0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        reset = 1'b1; wr_en = 8'd0; wr_data = 64'd0; err_clr = 1'b0;
        rd_addr_a = 3'b000; rd_addr_b = 3'b111;
        #2;
        checks++;
        if (rd_data_a0 !== 64'd0 || rd_data_b0 !== 64'd0 || rd_data_a1 !== 64'd0 ||
            rd_data_b1 !== 64'd0 || err0 !== 1'b0 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: a0=%h b0=%h a1=%h b1=%h err=%b%b expected all 0",
                     rd_data_a0, rd_data_b0, rd_data_a1, rd_data_b1, err0, err1);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_write;
        @(negedge clk);
        wr_en = 8'b0001_0000; wr_data = 64'h0123_4567_89AB_CDEF;
        rd_addr_a = 3'b001; rd_addr_b = 3'b100;
        @(posedge clk); #1;
        checks++;
        if (rd_data_a0 !== 64'h0123_4567_89AB_CDEF || rd_data_a1 !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL single_write_a: got %h/%h expected 0123456789abcdef", rd_data_a0, rd_data_a1);
        end
        checks++;
        if (rd_data_b0 !== 64'd0 || rd_data_b1 !== 64'd0) begin
            errors++;
            $display("FAIL single_write_b: got %h/%h expected 0", rd_data_b0, rd_data_b1);
        end
        @(negedge clk); wr_en = 8'd0;
    endtask

    task automatic test_zero_reg;
        @(negedge clk);
        wr_en = 8'b1000_0000; wr_data = '1;
        @(negedge clk); wr_en = 8'd0;
        rd_addr_a = 3'b111; rd_addr_b = 3'b111;
        #1;
        checks++;
        if (rd_data_a0 !== 64'd0) begin
            errors++;
            $display("FAIL zero_reg: dut0 reg7 got %h expected 0", rd_data_a0);
        end
        checks++;
        if (rd_data_b1 !== '1) begin
            errors++;
            $display("FAIL zero_reg_off: dut1 reg7 got %h expected all ones", rd_data_b1);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
            #1;
            checks++;
            if (rd_data_a0 !== model_rd(0, rd_addr_a) || rd_data_b0 !== model_rd(0, rd_addr_b)) begin
                errors++;
                $display("FAIL zero_reg_others addr=%0d: got %h/%h expected %h/%h", i,
                         rd_data_a0, rd_data_b0, model_rd(0, rd_addr_a), model_rd(0, rd_addr_b));
            end
        end
    endtask

    task automatic test_multi_hot;
        drive_write(0, 64'd5);
        drive_write(1, 64'd6);
        @(negedge clk);
        wr_en = 8'b0000_0011; wr_data = 64'hFFFF_0000_FFFF_0000;
        rd_addr_a = 3'b000; rd_addr_b = 3'b100;
        @(posedge clk); #1;
        checks++;
        if (rd_data_a0 !== 64'd5 || rd_data_a1 !== 64'd5 || rd_data_b0 !== 64'd6 || rd_data_b1 !== 64'd6) begin
            errors++;
            $display("FAIL multi_hot_data: got %h %h %h %h expected 5 5 6 6",
                     rd_data_a0, rd_data_a1, rd_data_b0, rd_data_b1);
        end
        checks++;
        if (err0 !== 1'b1 || err1 !== 1'b1) begin
            errors++;
            $display("FAIL multi_hot_flag: got %b%b expected 11", err0, err1);
        end
        @(negedge clk);
        wr_en = 8'd0; err_clr = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (err0 !== 1'b0 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: got %b%b expected 00", err0, err1);
        end
        @(negedge clk); err_clr = 1'b0;
    endtask

    task automatic test_set_clear;
        @(negedge clk);
        wr_en = 8'b1100_0000; err_clr = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (err0 !== 1'b1 || err1 !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear: got %b%b expected 11", err0, err1);
        end
        @(negedge clk);
        wr_en = 8'd0;
        @(posedge clk); #1;
        checks++;
        if (err0 !== 1'b0 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL clear_after_set: got %b%b expected 00", err0, err1);
        end
        @(negedge clk); err_clr = 1'b0;
    endtask

    task automatic test_bypass;
        drive_write(2, 64'h77);
        @(negedge clk);
        wr_en = 8'b0000_0100; wr_data = 64'h42;
        rd_addr_a = 3'b010; rd_addr_b = 3'b010;
        #1;
        checks++;
        if (rd_data_a1 !== 64'h42 || rd_data_b1 !== 64'h42) begin
            errors++;
            $display("FAIL bypass_on: got %h/%h expected 42", rd_data_a1, rd_data_b1);
        end
        checks++;
        if (rd_data_a0 !== 64'h77) begin
            errors++;
            $display("FAIL bypass_off_pre: got %h expected 77", rd_data_a0);
        end
        @(posedge clk); #1;
        checks++;
        if (rd_data_a0 !== 64'h42) begin
            errors++;
            $display("FAIL bypass_off_post: got %h expected 42", rd_data_a0);
        end
        // Multi-hot covering register 2 must not forward.
        @(negedge clk);
        wr_en = 8'b0000_0110; wr_data = 64'h99;
        #1;
        checks++;
        if (rd_data_a1 !== 64'h42) begin
            errors++;
            $display("FAIL bypass_multi_hot: got %h expected 42", rd_data_a1);
        end
        @(negedge clk);
        wr_en = 8'd0; err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
    endtask

    task automatic test_random;
        for (int n = 0; n < 300; n++) begin
            int kind;
            @(negedge clk);
            kind = $urandom_range(0, 3);
            if (kind == 0) wr_en = 8'd0;
            else if (kind < 3) wr_en = 8'd1 << $urandom_range(0, 7);
            else begin
                wr_en = 8'($urandom);
                while ($countones(wr_en) < 2) wr_en = 8'($urandom);
            end
            wr_data   = {$urandom, $urandom};
            rd_addr_a = 3'($urandom);
            rd_addr_b = 3'($urandom);
            err_clr   = ($urandom_range(0, 4) == 0);
            #1;
            checks++;
            if (rd_data_a0 !== model_rd(0, rd_addr_a) || rd_data_b0 !== model_rd(0, rd_addr_b) ||
                rd_data_a1 !== model_rd(1, rd_addr_a) || rd_data_b1 !== model_rd(1, rd_addr_b)) begin
                errors++;
                $display("FAIL random_pre n=%0d we=%b: got %h %h %h %h expected %h %h %h %h", n, wr_en,
                         rd_data_a0, rd_data_b0, rd_data_a1, rd_data_b1,
                         model_rd(0, rd_addr_a), model_rd(0, rd_addr_b),
                         model_rd(1, rd_addr_a), model_rd(1, rd_addr_b));
            end
            @(posedge clk); #1;
            checks++;
            if (rd_data_a0 !== model_rd(0, rd_addr_a) || rd_data_b0 !== model_rd(0, rd_addr_b) ||
                rd_data_a1 !== model_rd(1, rd_addr_a) || rd_data_b1 !== model_rd(1, rd_addr_b) ||
                err0 !== exp_err || err1 !== exp_err) begin
                errors++;
                $display("FAIL random_post n=%0d: got %h %h %h %h err %b%b expected %h %h %h %h err %b", n,
                         rd_data_a0, rd_data_b0, rd_data_a1, rd_data_b1, err0, err1,
                         model_rd(0, rd_addr_a), model_rd(0, rd_addr_b),
                         model_rd(1, rd_addr_a), model_rd(1, rd_addr_b), exp_err);
            end
        end
        @(negedge clk); wr_en = 8'd0; err_clr = 1'b0;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 8; i++) drive_write(i, 64'hDEAD_BEEF_0000_0001);
        @(negedge clk); wr_en = 8'h18;   // leave the error flag set
        @(negedge clk);
        wr_en = 8'h01; wr_data = 64'hABCD; rd_addr_a = 3'b000; rd_addr_b = 3'b001;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (rd_data_a0 !== 64'd0 || rd_data_b0 !== 64'd0 || rd_data_a1 !== 64'd0 ||
            rd_data_b1 !== 64'd0 || err0 !== 1'b0 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got %h %h %h %h err %b%b expected all 0",
                     rd_data_a0, rd_data_b0, rd_data_a1, rd_data_b1, err0, err1);
        end
        @(posedge clk); #1;
        checks++;
        if (rd_data_a0 !== 64'd0 || rd_data_a1 !== 64'd0) begin
            errors++;
            $display("FAIL reset_write_lost: got %h/%h expected 0", rd_data_a0, rd_data_a1);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rd_data_a0 !== 64'hABCD || rd_data_a1 !== 64'hABCD || rd_data_b0 !== 64'd0) begin
            errors++;
            $display("FAIL first_write_after_reset: got %h %h %h expected abcd abcd 0",
                     rd_data_a0, rd_data_a1, rd_data_b0);
        end
        @(negedge clk); wr_en = 8'd0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_zero_reg();
        test_multi_hot();
        test_set_clear();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register_bank_8x64
`default_nettype wire

// File: doc/register_bank_8x64.md
# register_bank_8x64

Eight-entry, 64-bit register bank that sits directly downstream of the 3-to-8 write-address decoder in the register-file datapath. It consumes the decoder's one-hot write-enable vector, writes one 64-bit word per cycle, and provides two combinational read ports. Register 7 is hardwired to zero when ZERO_REG_EN is set. A sticky flag records illegal multi-hot write enables.

## Interface
- WIDTH, 64: data word width.
- ZERO_REG_EN, 1: when 1, register 7 reads as zero and ignores writes.
- BYPASS_EN, 0: when 1, a read of the register being written this cycle returns wr_data.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- wr_en  input  8  one-hot write enable from the decoder; bit i selects register i; all-zero means no write.
- wr_data  input  WIDTH  write data.
- rd_addr_a  input  3  read port A address.
- rd_addr_b  input  3  read port B address.
- err_clr  input  1  synchronous clear of err_multi_hot.
- rd_data_a  output  WIDTH  read port A data.
- rd_data_b  output  WIDTH  read port B data.
- err_multi_hot  output  1  sticky: a wr_en with 2 or more bits set was sampled.

## Operation
- Read address bit order matches the write decoder. Register index = rd_addr[0]·4 + rd_addr[1]·2 + rd_addr[2]. For example, rd_addr = 3'b001 selects register 4, and 3'b100 selects register 1.
- Write: if wr_en has exactly one bit i set, register i ← wr_data on the rising clk edge. If ZERO_REG_EN = 1 and i = 7, the write is discarded.
- Zero bits set: no state change.
- Multi-hot (2 or more bits set): the whole write is suppressed and no register changes. err_multi_hot ← 1 on the same edge.
- err_multi_hot priority on a clock edge: multi-hot set > err_clr > hold. A simultaneous multi-hot write and err_clr leaves the flag at 1.
- Reads are combinational from register state:
  - rd_data = register[index].
  - Register 7 returns 0 when ZERO_REG_EN = 1.
- Bypass (BYPASS_EN = 1 only): if the read index equals the single-hot write index of the current cycle, rd_data = wr_data. Zero-register and multi-hot rules still apply: bypass never shows data that will not be written.
- Both read ports may address the same register, including the register being written.

## Timing
- Reset: all eight registers = 0 and err_multi_hot = 0, asynchronously. With all registers at zero, rd_data_a and rd_data_b read 0 during and immediately after reset.
- Write latency: data written at edge N is visible on the read ports after edge N. With BYPASS_EN = 1 it is visible in the cycle before edge N.
- Read path: combinational from address and register state; no clock latency.
- reset asserted mid-cycle while wr_en is active: reset wins, the write is lost, and the register stays 0 until reset deasserts.
- First rising edge after reset deasserts: normal write behaviour.
- Error flag: set on the rising edge that samples the multi-hot wr_en; visible after that edge; held until err_clr or reset.

## Structure
- Shared package regbank_pkg holds:
  - NUM_REGS = 8
  - REG_WIDTH = 64
  - ZERO_REG_IDX = 7
  - ADDR_W = 3
  - a function mapping a 3-bit address to an index using the decoder bit order
- Sub-module register_en: a WIDTH-bit register with enable and asynchronous active-high reset, instantiated 8 times. When ZERO_REG_EN = 1, the register-7 instance is replaced by constant zero.
- Top level contains:
  - a one-hot validity check (exactly-one detector)
  - the error flop
  - two 8:1 read multiplexers
  - optional bypass comparators

## Test plan
- Reset check: assert reset mid-simulation after loading registers with 64'hDEAD_BEEF_0000_0001 → all rd_data = 0 and err_multi_hot = 0 immediately, before any clock edge.
- Single write and readback: wr_en = 8'b0001_0000, wr_data = 64'h0123_4567_89AB_CDEF; after the edge, rd_addr_a = 3'b001 → 64'h0123_4567_89AB_CDEF; rd_addr_b = 3'b100 → 0.
- Zero register: ZERO_REG_EN = 1, wr_en = 8'b1000_0000, wr_data = all ones; rd_addr = 3'b111 → 0, and no other register changes.
- Multi-hot: wr_en = 8'b0000_0011 with prior contents 5 and 6 → registers 0 and 1 are unchanged and err_multi_hot = 1 after the edge. Next cycle err_clr = 1 → flag 0.
- Simultaneous set and clear: multi-hot wr_en together with err_clr = 1 → err_multi_hot = 1.
- Bypass: BYPASS_EN = 1, wr_en = 8'b0000_0100, wr_data = 64'h42, rd_addr_a = 3'b010 → rd_data_a = 64'h42 in the same cycle. With BYPASS_EN = 0 → old value until after the edge.
